instr_fetch: RTL

//  Fetch stage: initiator side of the instruction-memory request/response interface.

---
 rtl/core_pkg.sv | 16 +
 rtl/instr_fetch_if.sv | 20 ++
 rtl/instr_fetch_buf.sv | 59 +++++
 rtl/instr_fetch.sv | 84 ++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types and defaults; the fetch stage uses the entries below.
package core_pkg;

  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
  localparam int          FETCH_BUF_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bundle between fetch (master) and memory (slave).
interface instr_fetch_if;

  logic        mem_en_op;
  logic        instr_req_op;
  logic [31:0] instr_addr_op;
  logic        instr_valid_ip;
  logic [31:0] instr_data_ip;

  modport master (
    output mem_en_op, instr_req_op, instr_addr_op,
    input  instr_valid_ip, instr_data_ip
  );

  modport slave (
    input  mem_en_op, instr_req_op, instr_addr_op,
    output instr_valid_ip, instr_data_ip
  );

endinterface

// File: rtl/instr_fetch_buf.sv
// Circular FIFO of fetched {pc, instr} entries with push, pop and single-cycle flush.
module fetch_buf
  import core_pkg::*;
#(
  parameter  int DEPTH = FETCH_BUF_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count alone says which slots hold live data.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, single in-flight request tracking, issue throttling and redirect control
// in front of a small buffer that feeds decode.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
  input  logic               clock,
  input  logic               reset_n,
  instr_fetch_if.master      mem,
  input  logic               redirect_ip,
  input  logic [31:0]        redirect_pc_ip,
  input  logic               dec_ready_ip,
  output logic               dec_valid_op,
  output logic [31:0]        dec_instr_op,
  output logic [31:0]        dec_pc_op
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          mem_en;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;

  assign pop  = dec_valid_op & dec_ready_ip;
  assign push = mem.instr_valid_ip & inflight & ~redirect_ip & ~full;

  // Slots already claimed after this cycle's pop; the in-flight response is counted as taken.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue     = mem_en & ~redirect_ip & (occupancy < (CW+1)'(BUF_DEPTH));

  assign mem.mem_en_op     = mem_en;
  assign mem.instr_req_op  = issue;
  assign mem.instr_addr_op = mem_en ? pc : '0;

  assign dec_valid_op = ~empty;
  assign dec_instr_op = empty ? '0 : head.instr;
  assign dec_pc_op    = empty ? '0 : head.pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      mem_en      <= 1'b0;
    end else begin
      mem_en <= 1'b1;
      if (redirect_ip) begin
        pc       <= word_align(redirect_pc_ip);
        inflight <= 1'b0;
      end else if (issue) begin
        pc          <= pc + 32'd4;
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({inflight_pc, mem.instr_data_ip}),
    .pop       (pop),
    .flush     (redirect_ip),
    .count     (count),
    .head      (head),
    .empty     (empty),
    .full      (full)
  );

endmodule
